wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Round-robin arbiter that shares the single scoreboard write-back port between several variable-latency result producers (e.g. multiplier/divider, FPU, CSR buffer, uncached load path). It sits in the execute stage between those functional units and the scoreboard write port, holds one result per source in a private buffer, and grants one buffered result per cycle. Producers see a valid/ready handshake; the scoreboard side has no back-pressure.

## Interface
- NR_SRC, 4, number of requesting sources (2..8)
- DATA_W, 64, result width
- ID_W, 3, scoreboard transaction-ID width
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- flush_i  input  1  pipeline flush; discards all buffered results
- src_valid_i  input  NR_SRC  per-source result valid
- src_ready_o  output  NR_SRC  per-source buffer can accept this cycle
- src_data_i  input  NR_SRC*DATA_W  per-source result, source k at bits [k*DATA_W +: DATA_W]
- src_id_i  input  NR_SRC*ID_W  per-source transaction ID, same packing
- src_ex_i  input  NR_SRC  per-source exception flag
- wb_valid_o  output  1  write-back valid
- wb_data_o  output  DATA_W  write-back result
- wb_id_o  output  ID_W  write-back transaction ID
- wb_ex_o  output  1  write-back exception flag
- wb_src_o  output  $clog2(NR_SRC)  index of granted source
- conflict_cnt_o  output  32  cycles with ≥2 buffers occupied (see Configuration)

## Operation
- Per source k: one-entry buffer {full_q[k], data, id, ex}; round-robin pointer ptr_q ($clog2(NR_SRC) bits).
- Arbitration (combinational): among k with full_q[k]=1, grant the first k at or after ptr_q, searching upward with wrap from NR_SRC-1 to 0. At most one grant per cycle.
- wb_valid_o = |full_q & ~flush_i. wb_data_o/wb_id_o/wb_ex_o/wb_src_o show granted buffer; all zero when wb_valid_o=0.
- Grant consumes the buffer: full_q[g] clears at next edge unless refilled the same cycle.
- src_ready_o[k] = ~flush_i & (~full_q[k] | grant[k]). Capture when src_valid_i[k] & src_ready_o[k]; full_q[k] set at next edge.
- Simultaneous grant and capture on the same source: buffer replaced with new result, full_q[k] stays 1 (one result/cycle throughput for a winning source).
- Pointer: on a grant to g, ptr_q <= (g+1) mod NR_SRC; unchanged with no grant.
- Flush: at next edge all full_q cleared, no capture, no grant; ptr_q unchanged. src_valid_i during flush is dropped (producers are flushed too).
- src_valid_i with src_ready_o=0: producer must hold data stable until accepted; arbiter does not sample it.

## Timing
- Reset (rst_i high, asynchronous): full_q=0, ptr_q=0, conflict counter=0; hence src_ready_o=all ones (once flush_i low), wb_valid_o=0, wb_* outputs 0, conflict_cnt_o=0.
- Release of rst_i takes effect at the first clock edge after deassertion; reset mid-operation discards buffered results without write-back.
- Latency: result captured at edge N appears on the write-back port in cycle N+1 if granted, otherwise after waiting ≤NR_SRC-1 further cycles (starvation-free).
- Write-back port is combinational from state; scoreboard must accept every wb_valid_o cycle.

## Configuration
- WB_ARB_PERF_EN defined: 32-bit saturating counter increments every cycle with popcount(full_q) ≥ 2 and flush_i=0; holds at 0xFFFF_FFFF; cleared only by reset; driven on conflict_cnt_o.
- Not defined: no counter logic; conflict_cnt_o tied to 0.

## Test plan
- Reset: assert rst_i mid-cycle with src 1 buffered -> outputs clear immediately, wb_valid_o=0, src_ready_o=4'b1111 after release, no write-back of pending result.
- Single source: src 2 valid, data 0xDEAD, id 5 at edge N -> cycle N+1 wb_valid_o=1, wb_data_o=0xDEAD, wb_id_o=5, wb_src_o=2; next cycle wb_valid_o=0.
- Round-robin: all four sources captured at same edge with ptr 0 -> write-backs in order 0,1,2,3 on four consecutive cycles; src_ready_o[k] low while buffer k waits.
- Back-to-back same source: src 0 valid every cycle, others idle -> one write-back per cycle, ids 0,1,2,3 in order, src_ready_o[0] stays 1.
- Flush: sources 1 and 3 buffered, flush_i=1 one cycle -> wb_valid_o=0 that cycle, both buffers empty after, no later write-back of either ID.
- Perf (WB_ARB_PERF_EN): sources 0 and 1 buffered together for 1 cycle of conflict -> conflict_cnt_o=1; without macro conflict_cnt_o=0 throughout.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single scoreboard write-back port between NR_SRC
//   variable-latency result producers. Each source owns a one-entry buffer;
//   one buffered result is granted per cycle in round-robin order starting
//   at ptr_q. A granted source may refill its buffer in the same cycle,
//   giving one result per cycle for a lone active source.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             discard all buffered results, block capture/grant
//   src_valid_i/ready_o per-source handshake
//   src_data_i/id_i/ex_i per-source result, source k at [k*W +: W]
//   wb_valid_o, wb_*    write-back port (no back-pressure), zero when idle
//   wb_src_o            index of the granted source
//   conflict_cnt_o      saturating count of cycles with >=2 buffers occupied
//
// Optional feature: define WB_ARB_PERF_EN to build the conflict counter;
// otherwise conflict_cnt_o is tied to zero.
module wb_port_arbiter #(
  parameter int unsigned NR_SRC = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [NR_SRC-1:0]          src_valid_i,
  output logic [NR_SRC-1:0]          src_ready_o,
  input  logic [NR_SRC*DATA_W-1:0]   src_data_i,
  input  logic [NR_SRC*ID_W-1:0]     src_id_i,
  input  logic [NR_SRC-1:0]          src_ex_i,
  output logic                       wb_valid_o,
  output logic [DATA_W-1:0]          wb_data_o,
  output logic [ID_W-1:0]            wb_id_o,
  output logic                       wb_ex_o,
  output logic [$clog2(NR_SRC)-1:0]  wb_src_o,
  output logic [31:0]                conflict_cnt_o
);

  localparam int unsigned SRC_W = $clog2(NR_SRC);

  logic [NR_SRC-1:0] full_q;
  logic [DATA_W-1:0] data_q [NR_SRC];
  logic [ID_W-1:0]   id_q   [NR_SRC];
  logic [NR_SRC-1:0] ex_q;
  logic [SRC_W-1:0]  ptr_q;

  logic              found;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W:0]    cand_sum;
  logic [SRC_W-1:0]  cand;
  logic              grant_any;
  logic [NR_SRC-1:0] grant;
  logic [NR_SRC-1:0] capture;

  // Search upward from ptr_q with wrap; the extra sum bit keeps the modulo
  // correct when NR_SRC is not a power of two.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NR_SRC; i++) begin
      cand_sum = {1'b0, ptr_q} + (SRC_W+1)'(i);
      if (cand_sum >= (SRC_W+1)'(NR_SRC))
        cand_sum = cand_sum - (SRC_W+1)'(NR_SRC);
      cand = cand_sum[SRC_W-1:0];
      if (!found && full_q[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_any = found & ~flush_i;

  always_comb begin
    grant   = '0;
    capture = '0;
    for (int unsigned k = 0; k < NR_SRC; k++) begin
      grant[k]   = grant_any & (grant_idx == SRC_W'(k));
      capture[k] = src_valid_i[k] & src_ready_o[k];
    end
  end

  assign src_ready_o = {NR_SRC{~flush_i}} & (~full_q | grant);

  assign wb_valid_o = grant_any;
  assign wb_data_o  = grant_any ? data_q[grant_idx] : '0;
  assign wb_id_o    = grant_any ? id_q[grant_idx]   : '0;
  assign wb_ex_o    = grant_any ? ex_q[grant_idx]   : 1'b0;
  assign wb_src_o   = grant_any ? grant_idx         : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= '0;
      ex_q   <= '0;
      ptr_q  <= '0;
      for (int unsigned k = 0; k < NR_SRC; k++) begin
        data_q[k] <= '0;
        id_q[k]   <= '0;
      end
    end else if (flush_i) begin
      full_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NR_SRC; k++) begin
        // Capture wins over grant-clear so a winning source can refill.
        if (capture[k]) begin
          full_q[k] <= 1'b1;
          data_q[k] <= src_data_i[k*DATA_W +: DATA_W];
          id_q[k]   <= src_id_i[k*ID_W +: ID_W];
          ex_q[k]   <= src_ex_i[k];
        end else if (grant[k]) begin
          full_q[k] <= 1'b0;
        end
      end
      if (grant_any)
        ptr_q <= (grant_idx == SRC_W'(NR_SRC-1)) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [SRC_W:0] occ;
  logic           conflict;
  logic [31:0]    conflict_cnt_q;

  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < NR_SRC; k++)
      occ = occ + (SRC_W+1)'(full_q[k]);
  end

  assign conflict = (occ >= (SRC_W+1)'(2)) & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      conflict_cnt_q <= '0;
    else if (conflict && (conflict_cnt_q != '1))
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
  end

  assign conflict_cnt_o = conflict_cnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int unsigned NR_SRC = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ID_W   = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     flush = 1'b0;
  logic [NR_SRC-1:0]        src_valid = '0;
  logic [NR_SRC-1:0]        src_ready;
  logic [NR_SRC*DATA_W-1:0] src_data = '0;
  logic [NR_SRC*ID_W-1:0]   src_id = '0;
  logic [NR_SRC-1:0]        src_ex = '0;
  logic                     wb_valid;
  logic [DATA_W-1:0]        wb_data;
  logic [ID_W-1:0]          wb_id;
  logic                     wb_ex;
  logic [1:0]               wb_src;
  logic [31:0]              conflict_cnt;

  wb_port_arbiter #(.NR_SRC(NR_SRC), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_data_i(src_data), .src_id_i(src_id), .src_ex_i(src_ex),
    .wb_valid_o(wb_valid), .wb_data_o(wb_data), .wb_id_o(wb_id),
    .wb_ex_o(wb_ex), .wb_src_o(wb_src), .conflict_cnt_o(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        src;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              ex;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write-back must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb_id", 64'(wb_id), 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_src",  64'(wb_src),  64'(e.src));
        check("wb_id",   64'(wb_id),   64'(e.id));
        check("wb_data", wb_data,      e.data);
        check("wb_ex",   64'(wb_ex),   64'(e.ex));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic [ID_W-1:0] id,
                       input logic [DATA_W-1:0] data, input logic ex);
    src_valid[k] = 1'b1;
    src_id[k*ID_W +: ID_W] = id;
    src_data[k*DATA_W +: DATA_W] = data;
    src_ex[k] = ex;
  endtask

  task automatic expect_wb(input logic [1:0] s, input logic [ID_W-1:0] id,
                           input logic [DATA_W-1:0] data, input logic ex);
    exp_t e;
    e.src = s; e.id = id; e.data = data; e.ex = ex;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_wb_valid", 64'(wb_valid), 0);
    check("rst_ready", 64'(src_ready), 64'hF);
    check("rst_cnt", 64'(conflict_cnt), 0);
    tick();
    rst = 1'b0;
    tick();

    // Round-robin: all four captured at once, ptr=0 -> grants 0,1,2,3
    for (int k = 0; k < 4; k++)
      drive(k, 3'(k), 64'h100 + 64'(k), (k == 3));
    for (int k = 0; k < 4; k++)
      expect_wb(2'(k), 3'(k), 64'h100 + 64'(k), (k == 3));
    tick();
    src_valid = '0;
    check("rr_ready_0", 64'(src_ready), 64'b0001);
    tick();
    check("rr_ready_1", 64'(src_ready), 64'b0011);
    tick();
    check("rr_ready_2", 64'(src_ready), 64'b0111);
    tick();
    check("rr_ready_3", 64'(src_ready), 64'b1111);
    tick();
    check("rr_idle_valid", 64'(wb_valid), 0);
`ifdef WB_ARB_PERF_EN
    exp_cnt = exp_cnt + 3;   // occupancy 4,3,2 then 1
`endif
    check("rr_cnt", 64'(conflict_cnt), 64'(exp_cnt));

    // Single source 2: 0xDEAD id 5 (ptr 0 -> 3 afterwards)
    drive(2, 3'd5, 64'hDEAD, 1'b0);
    expect_wb(2'd2, 3'd5, 64'hDEAD, 1'b0);
    tick();
    src_valid = '0;
    check("single_valid", 64'(wb_valid), 1);
    check("single_ready", 64'(src_ready), 64'b1111);
    tick();
    check("single_after_valid", 64'(wb_valid), 0);
    check("single_after_data", wb_data, 0);
    check("single_after_src", 64'(wb_src), 0);

    // Back-to-back on source 0, ids 0..3 (ptr 3 -> wraps to 0)
    for (int i = 0; i < 4; i++) begin
      drive(0, 3'(i), 64'h200 + 64'(i), 1'b0);
      expect_wb(2'd0, 3'(i), 64'h200 + 64'(i), 1'b0);
      check("b2b_ready0", 64'(src_ready[0]), 1);
      tick();
    end
    src_valid = '0;
    tick();
    check("b2b_idle_valid", 64'(wb_valid), 0);
    check("b2b_cnt", 64'(conflict_cnt), 64'(exp_cnt));

    // Flush with sources 1 and 3 buffered (ptr now 1)
    drive(1, 3'd6, 64'h61, 1'b0);
    drive(3, 3'd7, 64'h73, 1'b1);
    tick();
    src_valid = '0;
    flush = 1'b1;
    #1;
    check("flush_wb_valid", 64'(wb_valid), 0);
    check("flush_ready", 64'(src_ready), 0);
    tick();
    flush = 1'b0;
    #1;
    check("post_flush_ready", 64'(src_ready), 64'b1111);
    check("post_flush_valid", 64'(wb_valid), 0);
    tick();
    tick();
    check("flush_cnt", 64'(conflict_cnt), 64'(exp_cnt));

    // Sources 0 and 1 together, ptr still 1 -> grants 1 then 0, one conflict cycle
    drive(0, 3'd1, 64'hA0, 1'b0);
    drive(1, 3'd2, 64'hB1, 1'b1);
    expect_wb(2'd1, 3'd2, 64'hB1, 1'b1);
    expect_wb(2'd0, 3'd1, 64'hA0, 1'b0);
    tick();
    src_valid = '0;
    tick();
    tick();
`ifdef WB_ARB_PERF_EN
    exp_cnt = exp_cnt + 1;
`endif
    check("perf_cnt", 64'(conflict_cnt), 64'(exp_cnt));

    // Reset mid-cycle with source 1 buffered: nothing written back
    drive(1, 3'd4, 64'hCAFE, 1'b0);
    tick();
    src_valid = '0;
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(wb_valid), 0);
    check("midrst_data", wb_data, 0);
    check("midrst_id", 64'(wb_id), 0);
    check("midrst_cnt", 64'(conflict_cnt), 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_ready", 64'(src_ready), 64'b1111);
    tick();
    check("midrst_after_valid", 64'(wb_valid), 0);
    tick();

    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
